force_cache_readout_controller: RTL and testbench
=================================================

FORCE_CACHE_READOUT_CONTROLLER -- requirements
Module: force_cache_readout_controller

Interface
REQ-001 SHALL have the following parameters (name, default, meaning):
- DATA_WIDTH, 32, width of one force component.
- CELL_X / CELL_Y / CELL_Z, 2 / 2 / 2, ID of the cell this unit serves.
- CELL_ID_WIDTH, 4, width of one cell coordinate.
- MAX_CELL_PARTICLE_NUM, 290, maximum number of particles in a cell.
- CELL_ADDR_WIDTH, 9, width of a particle address within a cell.
- PARTICLE_ID_WIDTH, CELL_ID_WIDTH*3+CELL_ADDR_WIDTH, width of a particle ID.
- OUT_BUF_DEPTH, 4, output buffer entries; this is also the maximum number of outstanding reads.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, asynchronous active-low reset.
- in_start, in, 1, one-cycle pulse that begins a cell readout.
- in_particle_num, in, CELL_ADDR_WIDTH, number of particles to read; sampled on in_start.
- out_read_data_request, out, 1, one-cycle strobe that issues a single force-cache read.
- out_cache_read_address, out, CELL_ADDR_WIDTH, address of the read being issued.
- in_cache_readout_valid, in, 1, force-cache read data is valid.
- in_partial_force, in, 3*DATA_WIDTH, force-cache read data as {x,y,z}.
- out_force_valid, out, 1, output entry available.
- in_downstream_ready, in, 1, downstream accepts the output entry.
- out_particle_id, out, PARTICLE_ID_WIDTH, ID of the output entry as {CELL_X,CELL_Y,CELL_Z,addr}.
- out_force, out, 3*DATA_WIDTH, accumulated force of the output entry.
- out_busy, out, 1, high in every state except IDLE.
- out_done, out, 1, one-cycle pulse at the end of a readout.

Function
REQ-003 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-004 SHALL, in IDLE on in_start:
- latch N = min(in_particle_num, MAX_CELL_PARTICLE_NUM);
- go to READ if N>0, else go directly to DONE.
REQ-005 SHALL ignore in_start in any state other than IDLE.
REQ-006 SHALL use particle addresses 1..N in ascending order; address 0 is never read.
REQ-007 SHALL, in READ, assert out_read_data_request for one cycle per address only when (outstanding reads + buffer occupancy) < OUT_BUF_DEPTH; reads may be issued back-to-back at one per cycle.
REQ-008 SHALL hold out_cache_read_address at the issued address during the strobe cycle.
REQ-009 SHALL go from READ to DRAIN in the cycle after the strobe for address N.
REQ-010 SHALL assume in-order cache returns at any fixed latency of 1 cycle or more; it SHALL NOT depend on the latency value.
REQ-011 SHALL keep a return-address counter starting at 1, incrementing on each in_cache_readout_valid while READ or DRAIN.
REQ-012 SHALL, on each such return, push {ID from the return counter, in_partial_force} into the output buffer in the same cycle.
REQ-013 SHALL ignore in_cache_readout_valid in IDLE or DONE (no push, no counter change).
REQ-014 SHALL keep the output buffer first-in first-out.
REQ-015 SHALL present the buffer head on out_particle_id/out_force with out_force_valid = buffer non-empty.
REQ-016 SHALL pop the head on (out_force_valid & in_downstream_ready); head data SHALL stay stable while valid and not ready.
REQ-017 SHALL support a push and a pop in the same cycle with occupancy unchanged.
REQ-018 SHALL, with an empty buffer, make pushed data visible on the output the cycle after the push (no combinational bypass).
REQ-019 SHALL never overflow the buffer, because of the REQ-007 credit rule.
REQ-020 SHALL go from DRAIN to DONE when N returns are received and the buffer is empty.
REQ-021 SHALL assert out_done for exactly one cycle in DONE, then return to IDLE.
REQ-022 SHALL drive out_busy = (state != IDLE).
REQ-023 SHALL keep out_read_data_request low outside READ.

Reset
REQ-024 SHALL, on rst low (asynchronous) at any time including mid-readout:
- go to IDLE;
- set all counters to 0;
- empty the buffer;
- set out_read_data_request, out_force_valid, out_busy and out_done to 0;
- set out_cache_read_address, out_particle_id and out_force to 0.
REQ-025 SHALL drop in-flight cache returns arriving after reset (rule REQ-013 applies).
REQ-026 SHALL resume normal operation on the first in_start after reset is released.

Verification
REQ-027 Basic:
- Stimulus: N=3, cache latency 2, in_downstream_ready=1, every return equal to {3F800000,3F800000,3F800000}.
- Required response: strobes at addresses 1,2,3 on consecutive cycles; out_particle_id values {2,2,2,1}, {2,2,2,2}, {2,2,2,3}, each with force 1.0,1.0,1.0; one out_done pulse; out_busy low afterwards.
REQ-028 Backpressure:
- Stimulus: N=10, in_downstream_ready=0 for 20 cycles, then 1.
- Required response: exactly 4 strobes before stall; no further strobe until a pop; all 10 IDs delivered in order with none lost or duplicated.
REQ-029 Zero and clamp:
- Stimulus: N=0, then N=300.
- Required response: N=0 gives out_done 1 cycle after in_start with no strobe; N=300 gives exactly 290 strobes, last address 290.
REQ-030 Reset mid-operation:
- Stimulus: rst low while in READ at address 5 with 2 reads outstanding.
- Required response: all outputs 0 immediately; late returns ignored; the next in_start with N=2 reads addresses 1 and 2 and outputs IDs ending in 1 and 2.
REQ-031 Ignored events:
- Stimulus: in_start pulsed during DRAIN; spurious in_cache_readout_valid while IDLE.
- Required response: no restart, no strobe, no output entry.
REQ-032 Simultaneous push and pop:
- Stimulus: latency 1, in_downstream_ready toggling every cycle.
- Required response: occupancy never exceeds 4; output order is 1..N.

Source files
------------

// File: rtl/force_cache_readout_controller.sv
// Reads particles 1..N of one cell out of the force cache and streams {particle ID, force}
// through a small FIFO; a credit check on issued reads keeps the FIFO from overflowing.
module force_cache_readout_controller #(
    parameter int DATA_WIDTH            = 32,
    parameter int CELL_X                = 2,
    parameter int CELL_Y                = 2,
    parameter int CELL_Z                = 2,
    parameter int CELL_ID_WIDTH         = 4,
    parameter int MAX_CELL_PARTICLE_NUM = 290,
    parameter int CELL_ADDR_WIDTH       = 9,
    parameter int PARTICLE_ID_WIDTH     = CELL_ID_WIDTH*3+CELL_ADDR_WIDTH,
    parameter int OUT_BUF_DEPTH         = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_start,
    input  logic [CELL_ADDR_WIDTH-1:0]   in_particle_num,
    output logic                         out_read_data_request,
    output logic [CELL_ADDR_WIDTH-1:0]   out_cache_read_address,
    input  logic                         in_cache_readout_valid,
    input  logic [3*DATA_WIDTH-1:0]      in_partial_force,
    output logic                         out_force_valid,
    input  logic                         in_downstream_ready,
    output logic [PARTICLE_ID_WIDTH-1:0] out_particle_id,
    output logic [3*DATA_WIDTH-1:0]      out_force,
    output logic                         out_busy,
    output logic                         out_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int CNT_W   = CELL_ADDR_WIDTH + 1;
    localparam int PTR_W   = (OUT_BUF_DEPTH > 1) ? $clog2(OUT_BUF_DEPTH) : 1;
    localparam int OCC_W   = $clog2(OUT_BUF_DEPTH + 1);
    localparam int FORCE_W = 3 * DATA_WIDTH;

    localparam logic [CELL_ID_WIDTH-1:0] CX = CELL_ID_WIDTH'(CELL_X);
    localparam logic [CELL_ID_WIDTH-1:0] CY = CELL_ID_WIDTH'(CELL_Y);
    localparam logic [CELL_ID_WIDTH-1:0] CZ = CELL_ID_WIDTH'(CELL_Z);

    logic [1:0]                 state;
    logic [CNT_W-1:0]           n_latched;
    logic [CNT_W-1:0]           issue_addr;
    logic [CNT_W-1:0]           ret_addr;
    logic [CNT_W-1:0]           n_clamped;
    logic [CNT_W:0]             committed;
    logic [CELL_ADDR_WIDTH-1:0] buf_addr  [OUT_BUF_DEPTH];
    logic [FORCE_W-1:0]         buf_force [OUT_BUF_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [OCC_W-1:0]           occupancy;
    logic                       issue;
    logic                       last_issue;
    logic                       push;
    logic                       pop;
    logic                       all_returned;

    // A read is only issued if its return is guaranteed a FIFO slot:
    // reads in flight plus entries already buffered must stay below the depth.
    always_comb begin
        n_clamped = (CNT_W'(in_particle_num) > CNT_W'(MAX_CELL_PARTICLE_NUM))
                  ? CNT_W'(MAX_CELL_PARTICLE_NUM) : CNT_W'(in_particle_num);
        committed    = {1'b0, issue_addr - ret_addr} + (CNT_W+1)'(occupancy);
        issue        = (state == READ) && (committed < (CNT_W+1)'(OUT_BUF_DEPTH));
        last_issue   = issue && (issue_addr == n_latched);
        push         = in_cache_readout_valid && ((state == READ) || (state == DRAIN));
        pop          = out_force_valid && in_downstream_ready;
        all_returned = (ret_addr == n_latched + 1'b1);
    end

    assign out_read_data_request  = issue;
    assign out_cache_read_address = issue ? issue_addr[CELL_ADDR_WIDTH-1:0] : '0;
    assign out_force_valid        = (occupancy != '0);
    assign out_particle_id        = out_force_valid
                                  ? PARTICLE_ID_WIDTH'({CX, CY, CZ, buf_addr[rd_ptr]}) : '0;
    assign out_force              = out_force_valid ? buf_force[rd_ptr] : '0;
    assign out_busy               = (state != IDLE);
    assign out_done               = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            n_latched  <= '0;
            issue_addr <= '0;
            ret_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_start) begin
                        n_latched  <= n_clamped;
                        issue_addr <= CNT_W'(1);
                        ret_addr   <= CNT_W'(1);
                        state      <= (n_clamped != '0) ? READ : DONE;
                    end
                end
                READ: begin
                    if (issue)      issue_addr <= issue_addr + 1'b1;
                    if (last_issue) state      <= DRAIN;
                end
                DRAIN: begin
                    if (all_returned && (occupancy == '0)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (push) ret_addr <= ret_addr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(OUT_BUF_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OUT_BUF_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr]  <= ret_addr[CELL_ADDR_WIDTH-1:0];
            buf_force[wr_ptr] <= in_partial_force;
        end
    end

endmodule

// File: tb/tb_force_cache_readout_controller.sv
// Bench for force_cache_readout_controller: in-order cache model with configurable latency,
// expected stream derived as IDs {2,2,2,1..N} carrying the cache contents at each address.
module tb_force_cache_readout_controller;

    localparam int DW    = 32;
    localparam int CAW   = 9;
    localparam int PIDW  = 21;
    localparam int FW    = 3 * DW;
    localparam int DEPTH = 4;
    localparam int MAXN  = 290;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_start = 1'b0;
    logic [CAW-1:0]  in_particle_num = '0;
    logic            out_read_data_request;
    logic [CAW-1:0]  out_cache_read_address;
    logic            in_cache_readout_valid = 1'b0;
    logic [FW-1:0]   in_partial_force = '0;
    logic            out_force_valid;
    logic            in_downstream_ready = 1'b1;
    logic [PIDW-1:0] out_particle_id;
    logic [FW-1:0]   out_force;
    logic            out_busy;
    logic            out_done;

    force_cache_readout_controller #(
        .DATA_WIDTH(DW), .CELL_X(2), .CELL_Y(2), .CELL_Z(2), .CELL_ID_WIDTH(4),
        .MAX_CELL_PARTICLE_NUM(MAXN), .CELL_ADDR_WIDTH(CAW), .PARTICLE_ID_WIDTH(PIDW),
        .OUT_BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_particle_num(in_particle_num),
        .out_read_data_request(out_read_data_request),
        .out_cache_read_address(out_cache_read_address),
        .in_cache_readout_valid(in_cache_readout_valid), .in_partial_force(in_partial_force),
        .out_force_valid(out_force_valid), .in_downstream_ready(in_downstream_ready),
        .out_particle_id(out_particle_id), .out_force(out_force),
        .out_busy(out_busy), .out_done(out_done)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int addr; } ret_t;

    ret_t            pend[$];
    logic [FW-1:0]   cache_mem [0:511];
    int              strobe_addr[$];
    int              strobe_cyc[$];
    logic [PIDW-1:0] rx_id[$];
    logic [FW-1:0]   rx_force[$];
    int              cyc = 0;
    int              lat = 2;
    int              done_cnt = 0;
    int              credit_viol = 0;
    int              stab_viol = 0;
    int              n_cmp = 0;
    int              n_bad = 0;
    logic            inject_valid = 1'b0;
    logic [FW-1:0]   inject_data = '0;
    logic            hold = 1'b0;
    logic [PIDW-1:0] held_id = '0;
    logic [FW-1:0]   held_force = '0;

    // Environment, evaluated mid-cycle: cache returns, strobe log, output log and protocol watch.
    always @(negedge clk) begin
        ret_t r;
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            in_cache_readout_valid = 1'b1;
            in_partial_force       = cache_mem[pend[0].addr];
            void'(pend.pop_front());
        end else if (inject_valid) begin
            in_cache_readout_valid = 1'b1;
            in_partial_force       = inject_data;
        end else begin
            in_cache_readout_valid = 1'b0;
            in_partial_force       = '0;
        end
        if (out_read_data_request) begin
            strobe_addr.push_back(int'(out_cache_read_address));
            strobe_cyc.push_back(cyc);
            if (strobe_addr.size() - rx_id.size() > DEPTH) credit_viol++;
            r.due  = cyc + lat;
            r.addr = int'(out_cache_read_address);
            pend.push_back(r);
        end
        if (hold && (!out_force_valid || out_particle_id !== held_id || out_force !== held_force))
            stab_viol++;
        if (out_force_valid && in_downstream_ready) begin
            rx_id.push_back(out_particle_id);
            rx_force.push_back(out_force);
        end
        hold       = rst && out_force_valid && !in_downstream_ready;
        held_id    = out_particle_id;
        held_force = out_force;
        if (out_done) done_cnt++;
    end

    function automatic logic [PIDW-1:0] exp_id(input int a);
        logic [CAW-1:0] aa;
        aa = CAW'(a);
        return {4'd2, 4'd2, 4'd2, aa};
    endfunction

    function automatic int rx_errors(input int n);
        int e = 0;
        if (rx_id.size() != n) return n + 1;
        for (int i = 0; i < n; i++)
            if (rx_id[i] !== exp_id(i + 1) || rx_force[i] !== cache_mem[i + 1]) e++;
        return e;
    endfunction

    function automatic int strobe_errors(input int n);
        int e = 0;
        if (strobe_addr.size() != n) return n + 1;
        for (int i = 0; i < n; i++)
            if (strobe_addr[i] != i + 1) e++;
        return e;
    endfunction

    task automatic fill_cache();
        for (int a = 0; a < 512; a++) cache_mem[a] = {$urandom, $urandom, $urandom};
    endtask

    task automatic clear_logs();
        strobe_addr.delete(); strobe_cyc.delete(); rx_id.delete(); rx_force.delete();
        credit_viol = 0; stab_viol = 0;
    endtask

    task automatic start_readout(input int n);
        @(posedge clk); #1;
        clear_logs();
        in_start = 1'b1; in_particle_num = CAW'(n);
        @(posedge clk); #1;
        in_start = 1'b0;
    endtask

    // rmode: 0 ready high, 1 toggling, 2 random, 3 low for 20 cycles then high
    task automatic wait_done(input int rmode, input int budget, output bit got, output int snap);
        int d0;
        d0 = done_cnt; got = 1'b0; snap = -1;
        for (int c = 0; c < budget; c++) begin
            case (rmode)
                0:       in_downstream_ready = 1'b1;
                1:       in_downstream_ready = 1'(c % 2);
                2:       in_downstream_ready = 1'($urandom_range(0, 1));
                default: in_downstream_ready = (c >= 20);
            endcase
            @(posedge clk); #1;
            if (c == 19) snap = strobe_addr.size();
            if (done_cnt != d0) begin got = 1'b1; break; end
        end
        in_downstream_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_read_data_request, out_cache_read_address, out_force_valid, out_particle_id,
             out_force, out_busy, out_done} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got nonzero outputs, need all 0");
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_busy !== 1'b0 || out_force_valid !== 1'b0 || out_read_data_request !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: busy=%b valid=%b req=%b need 0 0 0",
                              out_busy, out_force_valid, out_read_data_request);
        end
    endtask

    task automatic test_basic();
        bit got; int snap; int d0; bit consec;
        lat = 2;
        for (int a = 0; a < 512; a++) cache_mem[a] = {32'h3F800000, 32'h3F800000, 32'h3F800000};
        d0 = done_cnt;
        start_readout(3);
        wait_done(0, 200, got, snap);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (!got || strobe_errors(3) != 0) begin
            n_bad++; $display("FAIL basic_strobes: done=%0d strobes=%0d, need done=1 strobes 1,2,3", got, strobe_addr.size());
        end
        consec = strobe_cyc.size() == 3 && strobe_cyc[1] == strobe_cyc[0] + 1 && strobe_cyc[2] == strobe_cyc[1] + 1;
        n_cmp++;
        if (!consec) begin
            n_bad++; $display("FAIL basic_back_to_back: strobes not on consecutive cycles (count %0d), need 3 consecutive", strobe_cyc.size());
        end
        n_cmp++;
        if (rx_errors(3) != 0 || rx_force[0] !== {32'h3F800000, 32'h3F800000, 32'h3F800000}) begin
            n_bad++; $display("FAIL basic_outputs: got %0d entries with %0d errors, need IDs 222.1..3 force 1.0", rx_id.size(), rx_errors(3));
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || out_busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_done: done pulses=%0d busy=%b, need 1 and 0", done_cnt - d0, out_busy);
        end
    endtask

    task automatic test_backpressure();
        bit got; int snap;
        lat = 2; fill_cache();
        start_readout(10);
        wait_done(3, 400, got, snap);
        n_cmp++;
        if (snap != DEPTH) begin
            n_bad++; $display("FAIL bp_stall: got %0d strobes while stalled, need %0d", snap, DEPTH);
        end
        n_cmp++;
        if (!got || strobe_errors(10) != 0 || rx_errors(10) != 0) begin
            n_bad++; $display("FAIL bp_stream: done=%0d strobes=%0d rx=%0d, need done=1 10 and 10 in order",
                              got, strobe_addr.size(), rx_id.size());
        end
        n_cmp++;
        if (credit_viol != 0 || stab_viol != 0) begin
            n_bad++; $display("FAIL bp_protocol: credit violations=%0d unstable heads=%0d, need 0 0", credit_viol, stab_viol);
        end
    endtask

    task automatic test_zero_clamp();
        bit got; int snap;
        start_readout(0);
        n_cmp++;
        if (out_done !== 1'b1 || out_read_data_request !== 1'b0) begin
            n_bad++; $display("FAIL zero_done: done=%b req=%b one cycle after start, need 1 0", out_done, out_read_data_request);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_done !== 1'b0 || out_busy !== 1'b0 || strobe_addr.size() != 0) begin
            n_bad++; $display("FAIL zero_after: done=%b busy=%b strobes=%0d, need 0 0 0", out_done, out_busy, strobe_addr.size());
        end
        lat = 1; fill_cache();
        start_readout(300);
        wait_done(0, 3000, got, snap);
        n_cmp++;
        if (!got || strobe_errors(MAXN) != 0 || strobe_addr[strobe_addr.size()-1] != MAXN) begin
            n_bad++; $display("FAIL clamp_strobes: done=%0d strobes=%0d, need done=1 and %0d ending at %0d",
                              got, strobe_addr.size(), MAXN, MAXN);
        end
        n_cmp++;
        if (rx_errors(MAXN) != 0) begin
            n_bad++; $display("FAIL clamp_stream: got %0d entries %0d errors, need %0d correct", rx_id.size(), rx_errors(MAXN), MAXN);
        end
    endtask

    task automatic test_reset_mid();
        bit got; bit found; int snap;
        lat = 2; fill_cache();
        start_readout(10);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_read_data_request && out_cache_read_address == CAW'(5)) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (!found || {out_read_data_request, out_cache_read_address, out_force_valid, out_particle_id,
                       out_force, out_busy, out_done} !== '0) begin
            n_bad++; $display("FAIL midreset_outputs: reached addr5=%0d, outputs nonzero or not reached, need reached and all 0", found);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        clear_logs();
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (rx_id.size() != 0 || strobe_addr.size() != 0 || out_busy !== 1'b0 || pend.size() != 0) begin
            n_bad++; $display("FAIL midreset_late_returns: rx=%0d strobes=%0d busy=%b, need 0 0 0", rx_id.size(), strobe_addr.size(), out_busy);
        end
        start_readout(2);
        wait_done(0, 200, got, snap);
        n_cmp++;
        if (!got || strobe_errors(2) != 0 || rx_errors(2) != 0) begin
            n_bad++; $display("FAIL midreset_resume: done=%0d strobes=%0d rx=%0d, need 1 2 2 with IDs ending 1,2",
                              got, strobe_addr.size(), rx_id.size());
        end
    endtask

    task automatic test_ignored();
        bit got; int snap; int d0;
        lat = 2; fill_cache();
        in_downstream_ready = 1'b0;
        d0 = done_cnt;
        start_readout(4);
        in_downstream_ready = 1'b0;
        for (int c = 0; c < 30 && strobe_addr.size() < 4; c++) begin @(posedge clk); #1; end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_busy !== 1'b1 || out_read_data_request !== 1'b0) begin
            n_bad++; $display("FAIL ign_drain_state: busy=%b req=%b, need 1 0", out_busy, out_read_data_request);
        end
        in_start = 1'b1; in_particle_num = CAW'(7);
        @(posedge clk); #1;
        in_start = 1'b0;
        wait_done(0, 200, got, snap);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (!got || strobe_errors(4) != 0 || rx_errors(4) != 0 || done_cnt - d0 != 1) begin
            n_bad++; $display("FAIL ign_start_in_drain: strobes=%0d rx=%0d done=%0d, need 4 4 1",
                              strobe_addr.size(), rx_id.size(), done_cnt - d0);
        end
        clear_logs();
        inject_data = {$urandom, $urandom, $urandom};
        inject_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 inject_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (rx_id.size() != 0 || strobe_addr.size() != 0 || out_busy !== 1'b0) begin
            n_bad++; $display("FAIL ign_spurious_valid: rx=%0d strobes=%0d busy=%b, need 0 0 0", rx_id.size(), strobe_addr.size(), out_busy);
        end
        start_readout(2);
        wait_done(0, 200, got, snap);
        n_cmp++;
        if (!got || rx_errors(2) != 0) begin
            n_bad++; $display("FAIL ign_followup: done=%0d rx=%0d errors=%0d, need 1 2 0", got, rx_id.size(), rx_errors(2));
        end
    endtask

    task automatic test_push_pop();
        bit got; int snap; int n;
        lat = 1; fill_cache();
        n = $urandom_range(20, 40);
        start_readout(n);
        wait_done(1, 500, got, snap);
        n_cmp++;
        if (!got || strobe_errors(n) != 0 || rx_errors(n) != 0) begin
            n_bad++; $display("FAIL pushpop_stream: n=%0d done=%0d strobes=%0d rx=%0d errors=%0d, need all %0d in order",
                              n, got, strobe_addr.size(), rx_id.size(), rx_errors(n), n);
        end
        n_cmp++;
        if (credit_viol != 0 || stab_viol != 0) begin
            n_bad++; $display("FAIL pushpop_protocol: credit violations=%0d unstable heads=%0d, need 0 0", credit_viol, stab_viol);
        end
    endtask

    task automatic test_random();
        bit got; int snap; int n;
        for (int it = 0; it < 6; it++) begin
            lat = $urandom_range(1, 4); fill_cache();
            n = $urandom_range(1, 40);
            start_readout(n);
            wait_done(2, 1000, got, snap);
            n_cmp++;
            if (!got || strobe_errors(n) != 0 || rx_errors(n) != 0 || credit_viol != 0 || stab_viol != 0) begin
                n_bad++; $display("FAIL random_%0d: n=%0d lat=%0d done=%0d strobes=%0d rx=%0d credit=%0d stab=%0d, need done=1 %0d %0d 0 0",
                                  it, n, lat, got, strobe_addr.size(), rx_id.size(), credit_viol, stab_viol, n, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_clamp();
        test_reset_mid();
        test_ignored();
        test_push_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need all tests to complete");
        $fatal(1, "watchdog");
    end

endmodule
